// File: rtl/uart_tx_buffered_if.sv
// Producer-side byte handshake for the buffered UART transmitter.
// The producer drives tx_byte/tx_start; the transmitter answers with
// registered tx_busy (almost-full) and a one-cycle overflow pulse.
interface uart_tx_buffered_if;
  logic [7:0] tx_byte;
  logic       tx_start;
  logic       tx_busy;
  logic       overflow;

  // Producer side (command response generator).
  modport master (
    output tx_byte,
    output tx_start,
    input  tx_busy,
    input  overflow
  );

  // Transmitter side.
  modport slave (
    input  tx_byte,
    input  tx_start,
    output tx_busy,
    output overflow
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of a bit serialiser.
// Latency: write at edge E into an idle block -> pop at E+1 -> start bit driven after E+2.
// Backpressure: registered tx_busy when count >= DEPTH-1; writes to a full FIFO are dropped with an overflow pulse.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_AW      = 4
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_buffered_if.slave   bus,
  output logic                uart_txd,
  output logic                idle
);

  localparam int DEPTH       = 1 << FIFO_AW;
  localparam int DEPTH_M1    = DEPTH - 1;
  localparam int BW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BAUD_LAST_I = CLKS_PER_BIT - 1;

  localparam logic [FIFO_AW:0] CNT_FULL  = DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW:0] CNT_AFULL = DEPTH_M1[FIFO_AW:0];
  localparam logic [BW-1:0]    BAUD_LAST = BAUD_LAST_I[BW-1:0];

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [FIFO_AW:0]   count_nxt;
  logic               wr_en;
  logic               pop;

  // Serialiser state
  state_t       state;
  state_t       state_nxt;
  logic [BW-1:0] baud_cnt;
  logic [BW-1:0] baud_nxt;
  logic [2:0]   bit_idx;
  logic [2:0]   bit_idx_nxt;
  logic [7:0]   shreg;
  logic [7:0]   shreg_nxt;
  logic         txd_nxt;
  logic         baud_last;

  // Space is judged on the pre-edge count only, so a pop in the same
  // cycle never makes room for a write to a full FIFO.
  assign wr_en     = bus.tx_start && (count != CNT_FULL);
  assign baud_last = (baud_cnt == BAUD_LAST);

  // Next-state, pop request and shift-register update for the serialiser.
  always_comb begin
    state_nxt   = state;
    baud_nxt    = baud_cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    pop         = 1'b0;
    case (state)
      S_IDLE: begin
        baud_nxt = '0;
        if (count != '0) begin
          pop       = 1'b1;
          shreg_nxt = mem[rd_ptr];
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_nxt    = '0;
          bit_idx_nxt = 3'd0;
          state_nxt   = S_DATA;
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_nxt    = '0;
          shreg_nxt   = {1'b0, shreg[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_nxt = S_STOP;
          end
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_nxt  = '0;
          state_nxt = S_IDLE;
        end else begin
          baud_nxt = baud_cnt + BW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        baud_nxt  = '0;
      end
    endcase
  end

  // Line level is a function of the current (pre-edge) state; registering
  // it puts the line one cycle behind the state machine.
  always_comb begin
    txd_nxt = 1'b1;
    case (state)
      S_START: txd_nxt = 1'b0;
      S_DATA:  txd_nxt = shreg[0];
      default: txd_nxt = 1'b1;
    endcase
  end

  // Occupancy after this edge; simultaneous write and pop cancel out.
  always_comb begin
    count_nxt = count;
    case ({wr_en, pop})
      2'b10:   count_nxt = count + (FIFO_AW + 1)'(1);
      2'b01:   count_nxt = count - (FIFO_AW + 1)'(1);
      default: count_nxt = count;
    endcase
  end

  // FIFO data array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= bus.tx_byte;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      count <= count_nxt;
    end
  end

  // Serialiser state register; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shreg    <= 8'h00;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_idx_nxt;
      shreg    <= shreg_nxt;
    end
  end

  // Registered outputs: line, flow control, idle status and drop pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      uart_txd     <= 1'b1;
      bus.tx_busy  <= 1'b0;
      bus.overflow <= 1'b0;
      idle         <= 1'b1;
    end else begin
      uart_txd     <= txd_nxt;
      bus.tx_busy  <= (count_nxt >= CNT_AFULL);
      bus.overflow <= bus.tx_start && (count == CNT_FULL);
      idle         <= (count_nxt == '0) && (state_nxt == S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: cycle-level reference model plus a line decoder
// that pops expected bytes from a scoreboard queue as frames complete.
// Directed scenarios followed by randomized traffic with occasional resets.
module tb_uart_tx_buffered;

  localparam int C     = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * C;

  logic clk = 1'b0;
  logic rst;
  logic uart_txd;
  logic idle;

  uart_tx_buffered_if bus ();

  uart_tx_buffered #(.CLKS_PER_BIT(C), .FIFO_AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .uart_txd(uart_txd),
    .idle    (idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queue contents, time of the last pop, frame byte.
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  int         pop_edge = -1000;
  logic [7:0] fb = 8'h00;
  logic       exp_txd = 1'b1;
  logic       exp_busy = 1'b0;
  logic       exp_idle = 1'b1;
  logic       exp_ovf = 1'b0;
  int         edge_n = 0;

  // Observations collected by the monitor.
  int         ovf_cnt = 0;
  int         falls[$];
  int         idle_rise[$];
  logic [7:0] rx_log[$];

  // Advance the model across edge n using the inputs presented at that edge.
  task automatic model_step(input int n);
    int pre;
    int k;
    int b;
    bit do_pop;
    if (rst) begin
      mq.delete();
      sb.delete();
      pop_edge = -1000;
      exp_txd  = 1'b1;
      exp_busy = 1'b0;
      exp_idle = 1'b1;
      exp_ovf  = 1'b0;
      return;
    end
    pre    = mq.size();
    do_pop = (n - 1 >= pop_edge + FRAME) && (pre > 0);
    exp_ovf = bus.tx_start && (pre == DEPTH);
    if (do_pop) begin
      fb       = mq.pop_front();
      pop_edge = n;
    end
    if (bus.tx_start && pre < DEPTH) begin
      mq.push_back(bus.tx_byte);
      sb.push_back(bus.tx_byte);
    end
    exp_busy = (mq.size() >= DEPTH - 1);
    exp_idle = (mq.size() == 0) && (n >= pop_edge + FRAME);
    // The line shows bit k of the frame during the cycle after edge pop+1+k.
    k = n - (pop_edge + 1);
    if (k >= 0 && k < FRAME) begin
      b = k / C;
      if (b == 0)      exp_txd = 1'b0;
      else if (b == 9) exp_txd = 1'b1;
      else             exp_txd = fb[b-1];
    end else begin
      exp_txd = 1'b1;
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [7:0] b);
    rst          = r;
    bus.tx_start = s;
    bus.tx_byte  = b;
    @(posedge clk);
    model_step(edge_n);
    edge_n++;
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000; i++) begin
      if (mq.size() == 0 && sb.size() == 0 && edge_n > pop_edge + FRAME + 2) break;
      step(1'b0, 1'b0, 8'h00);
    end
    chk("drain_scoreboard_empty", sb.size(), 0);
  endtask

  // Monitor: per-cycle output comparison and mid-bit line decoding.
  initial begin
    bit         rx_active = 1'b0;
    int         rx_t = 0;
    logic [7:0] rx_byte = 8'h00;
    logic       prev_idle = 1'b1;
    forever begin
      @(negedge clk);
      if (edge_n > 0) begin
        chk("txd", uart_txd, exp_txd);
        chk("tx_busy", bus.tx_busy, exp_busy);
        chk("idle", idle, exp_idle);
        chk("overflow", bus.overflow, exp_ovf);
      end
      if (bus.overflow === 1'b1) ovf_cnt++;
      if (idle === 1'b1 && prev_idle !== 1'b1) idle_rise.push_back(edge_n - 1);
      prev_idle = idle;
      if (rst === 1'b1) begin
        rx_active = 1'b0;
      end else begin
        if (!rx_active && uart_txd === 1'b0) begin
          rx_active = 1'b1;
          rx_t      = 0;
          falls.push_back(edge_n - 1);
        end
        if (rx_active) begin
          if (rx_t % C == C / 2) begin
            int j;
            j = rx_t / C;
            if (j == 0) begin
              chk("start_bit", uart_txd, 1'b0);
            end else if (j <= 8) begin
              rx_byte[j-1] = uart_txd;
            end else begin
              chk("stop_bit", uart_txd, 1'b1);
              chk("byte_expected", (sb.size() > 0), 1);
              if (sb.size() > 0) chk("rx_byte", rx_byte, sb.pop_front());
              rx_log.push_back(rx_byte);
              rx_active = 1'b0;
            end
          end
          rx_t++;
        end
      end
    end
  end

  // Producer that honours tx_busy and sends a message.
  task automatic send_msg(input logic [7:0] msg[$]);
    int i;
    int t;
    i = 0;
    t = 0;
    while (i < msg.size() && t < 1000) begin
      if (bus.tx_busy !== 1'b1) begin
        step(1'b0, 1'b1, msg[i]);
        i++;
      end else begin
        step(1'b0, 1'b0, 8'h00);
      end
      t++;
    end
    chk("msg_all_sent", i, msg.size());
  endtask

  task automatic chk_log(input string name, input logic [7:0] msg[$]);
    chk({name, "_count"}, rx_log.size(), msg.size());
    for (int i = 0; i < msg.size() && i < rx_log.size(); i++) begin
      chk(name, rx_log[i], msg[i]);
    end
  endtask

  initial begin
    int w;
    int ovf0;
    logic [7:0] msg[$];
    rst          = 1'b1;
    bus.tx_start = 1'b0;
    bus.tx_byte  = 8'h00;
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    chk("reset_txd", uart_txd, 1'b1);
    chk("reset_busy", bus.tx_busy, 1'b0);
    chk("reset_idle", idle, 1'b1);
    chk("reset_overflow", bus.overflow, 1'b0);
    repeat (3) step(1'b0, 1'b0, 8'h00);

    // Single byte 0x4F.
    falls.delete(); idle_rise.delete(); rx_log.delete();
    w = edge_n;
    step(1'b0, 1'b1, 8'h4F);
    drain();
    chk("single_fall_latency", (falls.size() > 0) ? falls[0] - w : -1, 2);
    // idle follows the serialiser state, which runs one cycle ahead of the line.
    chk("single_idle_after_fall",
        (falls.size() > 0 && idle_rise.size() > 0) ? idle_rise[0] - falls[0] : -1, FRAME - 1);
    msg = '{8'h4F};
    chk_log("single_rx", msg);

    // Burst "OK\r\n" with flow control honoured.
    falls.delete(); rx_log.delete(); ovf0 = ovf_cnt;
    msg = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
    send_msg(msg);
    drain();
    chk_log("burst_rx", msg);
    for (int i = 1; i < 4; i++) begin
      chk("burst_start_spacing", (falls.size() > i) ? falls[i] - falls[i-1] : -1, FRAME + 1);
    end
    chk("burst_no_overflow", ovf_cnt - ovf0, 0);

    // Overrun: six writes back to back, tx_busy ignored.
    falls.delete(); rx_log.delete(); ovf0 = ovf_cnt;
    w = edge_n;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b1, 8'h41 + 8'(k));
      if (k == 2) chk("overrun_busy_e2", bus.tx_busy, 1'b0);
      if (k == 3) chk("overrun_busy_e3", bus.tx_busy, 1'b1);
      if (k == 4) chk("overrun_ovf_e4", bus.overflow, 1'b0);
      if (k == 5) chk("overrun_ovf_e5", bus.overflow, 1'b1);
    end
    drain();
    chk("overrun_fall_latency", (falls.size() > 0) ? falls[0] - w : -1, 2);
    chk("overrun_one_pulse", ovf_cnt - ovf0, 1);
    msg = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    chk_log("overrun_rx", msg);

    // Reset during data bit 3 of 0x41.
    rx_log.delete();
    w = edge_n;
    step(1'b0, 1'b1, 8'h41);
    step(1'b0, 1'b1, 8'h42);
    while (edge_n < w + 19) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    chk("midreset_txd", uart_txd, 1'b1);
    chk("midreset_idle", idle, 1'b1);
    chk("midreset_busy", bus.tx_busy, 1'b0);
    falls.delete();
    repeat (60) step(1'b0, 1'b0, 8'h00);
    chk("midreset_no_start", falls.size(), 0);
    step(1'b0, 1'b1, 8'h5A);
    drain();
    msg = '{8'h5A};
    chk_log("midreset_rx", msg);

    // Response generator ERR reply.
    rx_log.delete(); ovf0 = ovf_cnt;
    msg = '{8'h45, 8'h52, 8'h52, 8'h0D, 8'h0A};
    send_msg(msg);
    drain();
    chk_log("err_rx", msg);
    chk("err_no_overflow", ovf_cnt - ovf0, 0);

    // Randomized traffic: mixed polite/impolite producer, rare resets.
    for (int i = 0; i < 1500; i++) begin
      logic r;
      logic s;
      r = ($urandom_range(0, 399) == 0);
      s = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1 && bus.tx_busy === 1'b1) s = 1'b0;
      step(r, s, 8'($urandom));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
